// File: rtl/data_memory_param.sv
// Single-port 32-bit data memory with byte/halfword/word loads and stores,
// one-cycle response latency and an optional zero-fill sweep after reset.
module data_memory_param #(
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 64,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CLR_W  = IDX_W + 1;
    localparam int WIDX_W = ADDR_W - 2;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] extract_load(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic        sgn
    );
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   res = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   res = {{16{sgn & sh[15]}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    logic [31:0]       mem_r [DEPTH];
    state_t            state_r;
    state_t            state_next_s;
    logic [CLR_W-1:0]  clr_idx_r;
    logic              ready_r;
    logic              rsp_valid_r;
    logic              rsp_err_r;
    logic [31:0]       rsp_rdata_r;

    logic [WIDX_W-1:0] word_idx_s;
    logic [IDX_W-1:0]  mem_idx_s;
    logic [1:0]        offset_s;
    logic              accept_s;
    logic              size_err_s;
    logic              err_s;
    logic              store_s;
    logic              clr_we_s;
    logic [3:0]        be_s;
    logic [31:0]       st_data_s;
    logic [31:0]       rd_word_s;
    logic [31:0]       load_data_s;

    assign word_idx_s  = req_addr[ADDR_W-1:2];
    assign mem_idx_s   = word_idx_s[IDX_W-1:0];
    assign offset_s    = req_addr[1:0];
    assign accept_s    = req_valid & ready_r;
    assign store_s     = accept_s & req_we & ~err_s;
    assign rd_word_s   = mem_r[mem_idx_s];
    assign load_data_s = extract_load(rd_word_s, req_size, offset_s, req_signed);

    // Request decode: lane enables, replicated store data and error detection
    always_comb begin
        size_err_s = 1'b0;
        be_s       = 4'b0000;
        st_data_s  = 32'h0000_0000;
        case (req_size)
            2'b00: begin
                size_err_s = 1'b0;
                be_s       = 4'b0001 << offset_s;
                st_data_s  = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                size_err_s = offset_s[0];
                be_s       = 4'b0011 << offset_s;
                st_data_s  = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                size_err_s = (offset_s != 2'b00);
                be_s       = 4'b1111;
                st_data_s  = req_wdata;
            end
            default: begin
                size_err_s = 1'b1;
                be_s       = 4'b0000;
                st_data_s  = 32'h0000_0000;
            end
        endcase
        if (32'(word_idx_s) >= 32'(DEPTH)) begin
            err_s = 1'b1;
        end else begin
            err_s = size_err_s;
        end
    end

    // Next-state logic: sweep every word once, then stay ready until reset
    always_comb begin
        state_next_s = state_r;
        clr_we_s     = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                clr_we_s = 1'b1;
                if (clr_idx_r == CLR_LAST) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_READY: begin
                state_next_s = ST_READY;
            end
            default: begin
                state_next_s = RST_STATE;
            end
        endcase
    end

    // State register, sweep counter and registered ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= RST_STATE;
            clr_idx_r <= {CLR_W{1'b0}};
            ready_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == ST_READY);
            if (clr_we_s) begin
                clr_idx_r <= clr_idx_r + CLR_W'(1);
            end
        end
    end

    // Memory array; the sweep and stores never coincide since ready is low while sweeping
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_r[clr_idx_r[IDX_W-1:0]] <= 32'h0000_0000;
        end else if (store_s) begin
            mem_r[mem_idx_s] <= merge_lanes(rd_word_s, st_data_s, be_s);
        end
    end

    // One-cycle response pulse for every accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else begin
            rsp_valid_r <= accept_s;
            rsp_err_r   <= accept_s & err_s;
            rsp_rdata_r <= (accept_s && !req_we && !err_s) ? load_data_s : 32'h0000_0000;
        end
    end

    assign req_ready = ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;

endmodule
